// File: rtl/nonogram_line_engine_pkg.sv
// Shared types and sizing helpers for the nonogram line engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents: default board geometry, record-width helper, FSM state encoding.
package nonogram_line_engine_pkg;

    localparam int DEF_ROWS     = 11;
    localparam int DEF_COLS     = 11;
    localparam int DEF_MAX_OPTS = 64;

    function automatic int nono_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Record = {idx[IDX_W], cnt[CNT_W], opts[MAX_OPTS*LEN]}
    function automatic int nono_rec_w(input int rows, input int cols, input int max_opts);
        return $clog2(rows + cols) + $clog2(max_opts + 1) + max_opts * nono_max(rows, cols);
    endfunction

    // ST_STALL is only reachable when stall detection is compiled in.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_FILTER,
        ST_COMMIT,
        ST_PUSH,
        ST_DONE,
        ST_FAIL,
        ST_STALL
    } state_t;

endpackage

// File: rtl/nonogram_line_engine_if.sv
// Line-FIFO connection between the engine (master) and the record FIFO (slave).
// Latency: pop data is valid the cycle after fifo_rd_en.
// Backpressure: fifo_full holds off fifo_wr_en; fifo_empty ends the solve.
//
// Signals: fifo_empty, fifo_full, fifo_rd_data (FIFO -> engine);
//          fifo_rd_en, fifo_wr_en, fifo_wr_data (engine -> FIFO).
interface nonogram_line_engine_if
    import nonogram_line_engine_pkg::*;
#(
    parameter int REC_W = nono_rec_w(DEF_ROWS, DEF_COLS, DEF_MAX_OPTS)
);
    logic             fifo_empty;
    logic             fifo_full;
    logic [REC_W-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             fifo_wr_en;
    logic [REC_W-1:0] fifo_wr_data;

    modport master (
        input  fifo_empty, fifo_full, fifo_rd_data,
        output fifo_rd_en, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output fifo_empty, fifo_full, fifo_rd_data,
        input  fifo_rd_en, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/nonogram_line_engine_option_filter.sv
// Option filter: tests one candidate against the line's known/assigned bits and accumulates survivors.
// Latency: survive_o is combinational; accumulators update on the next clock edge.
// Backpressure: none; the caller presents one option per enabled cycle.
//
// Ports: clk, rst (async, active-high), clr_i (reset accumulators), en_i (option valid),
//        opt_i / a_i / k_i (option, assigned, known), survive_o, and_acc_o, or_acc_o.
module nonogram_line_engine_option_filter #(
    parameter int LEN = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [LEN-1:0] opt_i,
    input  logic [LEN-1:0] a_i,
    input  logic [LEN-1:0] k_i,
    output logic           survive_o,
    output logic [LEN-1:0] and_acc_o,
    output logic [LEN-1:0] or_acc_o
);
    logic [LEN-1:0] and_q;
    logic [LEN-1:0] or_q;

    // An option is consistent iff it agrees with the board on every known cell.
    assign survive_o = (((opt_i ^ a_i) & k_i) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_q <= '1;
            or_q  <= '0;
        end else if (clr_i) begin
            and_q <= '1;
            or_q  <= '0;
        end else if (en_i && survive_o) begin
            and_q <= and_q & opt_i;
            or_q  <= or_q | opt_i;
        end
    end

    assign and_acc_o = and_q;
    assign or_acc_o  = or_q;
endmodule

// File: rtl/nonogram_line_engine.sv
// Nonogram line solver: pops line records, filters options against the board, commits common cells.
// Latency: per line 1 pop + 1 wait + cnt filter + 1 commit (+ >=1 push cycles when re-queued).
// Backpressure: PUSH waits with fifo_wr_en low while fifo_full; empty FIFO at POP ends in DONE.
//
// Ports: clk, rst (async, active-high), start (pulse, IDLE only), fifo_if (line FIFO, master side),
//        board_known / board_assigned (bit r*COLS+c), busy, solved, unsolvable, stuck.
// Build option: NONO_STALL_DETECT_EN adds a no-progress counter and the STALL state; otherwise stuck=0.
module nonogram_line_engine
    import nonogram_line_engine_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int MAX_OPTS = DEF_MAX_OPTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    nonogram_line_engine_if.master fifo_if,
    output logic [ROWS*COLS-1:0]   board_known,
    output logic [ROWS*COLS-1:0]   board_assigned,
    output logic                   busy,
    output logic                   solved,
    output logic                   unsolvable,
    output logic                   stuck
);
    localparam int LEN    = nono_max(ROWS, COLS);
    localparam int LINES  = ROWS + COLS;
    localparam int IDX_W  = $clog2(LINES);
    localparam int CNT_W  = $clog2(MAX_OPTS + 1);
    localparam int OPTS_W = MAX_OPTS * LEN;
    localparam int REC_W  = IDX_W + CNT_W + OPTS_W;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [CNT_W-1:0]  cnt;
        logic [OPTS_W-1:0] opts;
    } line_rec_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q, k_q, surv_q;
    logic [OPTS_W-1:0]    opts_q, obuf_q;
    logic [LEN-1:0]       mask_q, line_k_q, line_a_q;
    logic [ROWS*COLS-1:0] known_q, assigned_q;
    logic                 busy_q, solved_q, unsolvable_q;

    logic [REC_W-1:0]     rd_raw;
    line_rec_t            rd_rec;
    logic [CNT_W-1:0]     cnt_in;

    assign rd_raw = fifo_if.fifo_rd_data;
    assign rd_rec = rd_raw;
    assign cnt_in = (rd_rec.cnt > CNT_W'(MAX_OPTS)) ? CNT_W'(MAX_OPTS) : rd_rec.cnt;

    // Gather the incoming line's known/assigned bits; columns take one bit from each row.
    logic [LEN-1:0] gat_k, gat_a, gat_mask;
    always_comb begin
        gat_k    = '0;
        gat_a    = '0;
        gat_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rd_rec.idx == IDX_W'(r)) begin
                    gat_mask[c] = 1'b1;
                    gat_k[c]    = known_q[r*COLS+c];
                    gat_a[c]    = assigned_q[r*COLS+c];
                end
                if (rd_rec.idx == IDX_W'(ROWS + c)) begin
                    gat_mask[r] = 1'b1;
                    gat_k[r]    = known_q[r*COLS+c];
                    gat_a[r]    = assigned_q[r*COLS+c];
                end
            end
        end
    end

    // Current option; bits beyond the line length are discarded before filtering.
    logic [OPTS_W-1:0] opts_sh;
    logic [LEN-1:0]    cur_opt;
    assign opts_sh = opts_q >> (int'(k_q) * LEN);
    assign cur_opt = opts_sh[LEN-1:0] & mask_q;

    logic           survive;
    logic [LEN-1:0] and_acc, or_acc;

    nonogram_line_engine_option_filter #(.LEN(LEN)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_WAIT),
        .en_i      (state_q == ST_FILTER),
        .opt_i     (cur_opt),
        .a_i       (line_a_q),
        .k_i       (line_k_q),
        .survive_o (survive),
        .and_acc_o (and_acc),
        .or_acc_o  (or_acc)
    );

    // Cells filled in every survivor or empty in every survivor become known.
    logic [LEN-1:0] new_k, new_a;
    logic           progress, line_done;
    assign new_k     = (line_k_q | and_acc | ~or_acc) & mask_q;
    assign new_a     = and_acc & mask_q;
    assign progress  = (new_k != line_k_q);
    assign line_done = (surv_q == CNT_W'(1)) || (new_k == mask_q);

    // Scatter the committed line back into a full-board image.
    logic [ROWS*COLS-1:0] known_d, assigned_d;
    always_comb begin
        known_d    = known_q;
        assigned_d = assigned_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (idx_q == IDX_W'(r)) begin
                    known_d[r*COLS+c]    = new_k[c];
                    assigned_d[r*COLS+c] = new_a[c];
                end
                if (idx_q == IDX_W'(ROWS + c)) begin
                    known_d[r*COLS+c]    = new_k[r];
                    assigned_d[r*COLS+c] = new_a[r];
                end
            end
        end
    end

`ifdef NONO_STALL_DETECT_EN
    localparam int SC_W = $clog2(LINES + 1);
    logic [SC_W-1:0] stall_cnt_q;
    logic [SC_W-1:0] stall_cnt_d;
    logic            stuck_q;
    assign stall_cnt_d = progress ? '0 : (stall_cnt_q + SC_W'(1));
    assign stuck       = stuck_q;
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            surv_q       <= '0;
            opts_q       <= '0;
            obuf_q       <= '0;
            mask_q       <= '0;
            line_k_q     <= '0;
            line_a_q     <= '0;
            known_q      <= '0;
            assigned_q   <= '0;
            busy_q       <= 1'b0;
            solved_q     <= 1'b0;
            unsolvable_q <= 1'b0;
`ifdef NONO_STALL_DETECT_EN
            stall_cnt_q  <= '0;
            stuck_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_POP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_POP: begin
                    if (fifo_if.fifo_empty) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        solved_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    idx_q    <= rd_rec.idx;
                    cnt_q    <= cnt_in;
                    opts_q   <= rd_rec.opts;
                    obuf_q   <= '0;
                    k_q      <= '0;
                    surv_q   <= '0;
                    mask_q   <= gat_mask;
                    line_k_q <= gat_k;
                    line_a_q <= gat_a;
                    if (rd_rec.cnt == '0) begin
                        state_q      <= ST_FAIL;
                        busy_q       <= 1'b0;
                        unsolvable_q <= 1'b1;
                    end else begin
                        state_q <= ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    if (survive) begin
                        obuf_q <= obuf_q | (OPTS_W'(cur_opt) << (int'(surv_q) * LEN));
                        surv_q <= surv_q + CNT_W'(1);
                    end
                    k_q <= k_q + CNT_W'(1);
                    if ((k_q + CNT_W'(1)) == cnt_q) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (surv_q == '0) begin
                        state_q      <= ST_FAIL;
                        busy_q       <= 1'b0;
                        unsolvable_q <= 1'b1;
                    end else begin
                        known_q    <= known_d;
                        assigned_q <= assigned_d;
`ifdef NONO_STALL_DETECT_EN
                        stall_cnt_q <= stall_cnt_d;
                        if (stall_cnt_d == SC_W'(LINES)) begin
                            state_q <= ST_STALL;
                            busy_q  <= 1'b0;
                            stuck_q <= 1'b1;
                        end else
`endif
                        if (line_done) begin
                            state_q <= ST_POP;
                        end else begin
                            state_q <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (!fifo_if.fifo_full) begin
                        state_q <= ST_POP;
                    end
                end
                default: begin
                    // DONE / FAIL / STALL are terminal until reset.
                end
            endcase
        end
    end

    // Strobes are decoded from the state register so the pop lands in the POP cycle itself
    // (data then valid in WAIT) and the push can never coincide with a pop.
    assign fifo_if.fifo_rd_en   = (state_q == ST_POP) && !fifo_if.fifo_empty;
    assign fifo_if.fifo_wr_en   = (state_q == ST_PUSH) && !fifo_if.fifo_full;
    assign fifo_if.fifo_wr_data = {idx_q, surv_q, obuf_q};

    assign board_known    = known_q;
    assign board_assigned = assigned_q;
    assign busy           = busy_q;
    assign solved         = solved_q;
    assign unsolvable     = unsolvable_q;
endmodule

// File: tb/tb_nonogram_line_engine.sv
// Testbench for nonogram_line_engine on a 5x5 board with 4 option slots.
// Latency: n/a. Backpressure: fifo_full is driven by the bench to stall pushes.
// Stimulus loads a behavioural FIFO; a negedge monitor scores every push against an expected queue.
module tb_nonogram_line_engine;
    import nonogram_line_engine_pkg::*;

    localparam int ROWS     = 5;
    localparam int COLS     = 5;
    localparam int MAX_OPTS = 4;
    localparam int N        = ROWS * COLS;
    localparam int REC_W    = nono_rec_w(ROWS, COLS, MAX_OPTS);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] board_known, board_assigned;
    logic         busy, solved, unsolvable, stuck;

    nonogram_line_engine_if #(.REC_W(REC_W)) fif ();

    nonogram_line_engine #(.ROWS(ROWS), .COLS(COLS), .MAX_OPTS(MAX_OPTS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .fifo_if        (fif),
        .board_known    (board_known),
        .board_assigned (board_assigned),
        .busy           (busy),
        .solved         (solved),
        .unsolvable     (unsolvable),
        .stuck          (stuck)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int push_cnt   = 0;
    logic [REC_W-1:0] fifo_q[$];
    logic [REC_W-1:0] exp_q[$];

    function automatic logic [REC_W-1:0] mk(input int idx, input int cnt,
                                            input logic [4:0] o0, input logic [4:0] o1,
                                            input logic [4:0] o2, input logic [4:0] o3);
        return {4'(idx), 3'(cnt), o3, o2, o1, o0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural line FIFO: data appears one cycle after the pop strobe.
    always @(posedge clk) begin
        if (fif.fifo_rd_en === 1'b1) begin
            #1;
            if (fifo_q.size() > 0) begin
                fif.fifo_rd_data = fifo_q.pop_front();
            end else begin
                mismatched++;
                $display("FAIL fifo_underflow: pop with empty queue");
            end
            fif.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Scoreboard monitor for pushes and strobe rules.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (fif.fifo_rd_en && fif.fifo_wr_en) begin
                mismatched++;
                $display("FAIL rd_wr_overlap: rd_en=1 wr_en=1, required not both");
            end
            if (fif.fifo_wr_en) begin
                push_cnt++;
                if (fif.fifo_full) begin
                    mismatched++;
                    $display("FAIL wr_while_full: wr_en=1 with fifo_full=1");
                end
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_push: data 0x%0h, no push expected", fif.fifo_wr_data);
                end else begin
                    logic [REC_W-1:0] e;
                    e = exp_q.pop_front();
                    if (fif.fifo_wr_data !== e) begin
                        mismatched++;
                        $display("FAIL push_data: got 0x%0h, expected 0x%0h", fif.fifo_wr_data, e);
                    end
                end
            end
        end
    end

    task automatic load(input logic [REC_W-1:0] rec);
        fifo_q.push_back(rec);
        fif.fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        start            = 1'b0;
        fif.fifo_full    = 1'b0;
        fif.fifo_empty   = 1'b1;
        fif.fifo_rd_data = '0;
        fifo_q.delete();
        exp_q.delete();
        push_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (solved || unsolvable || stuck) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no terminal flag within 300 cycles", nm);
        end
    endtask

    function automatic logic [31:0] status();
        return {28'd0, busy, solved, unsolvable, stuck};
    endfunction

    initial begin
        logic [REC_W-1:0] r2;
        bit seen;
        r2 = mk(1, 2, 5'b11100, 5'b01110, 5'b0, 5'b0);

        // Reset state
        do_reset();
        chk("rst_known", 32'(board_known), 32'h0);
        chk("rst_assigned", 32'(board_assigned), 32'h0);
        chk("rst_status", status(), 32'h0);
        chk("rst_strobes", {30'd0, fif.fifo_rd_en, fif.fifo_wr_en}, 32'h0);

        // 1: single option resolves row 0
        load(mk(0, 1, 5'b10110, 5'b0, 5'b0, 5'b0));
        pulse_start();
        wait_end("t1");
        chk("t1_status", status(), 32'b0100);
        chk("t1_known", 32'(board_known), 32'h1F);
        chk("t1_assigned", 32'(board_assigned), 32'h16);
        chk("t1_pushes", push_cnt, 0);

        // 2: two options on row 1: filled 2,3 and empty 0 become known; record re-queued
        do_reset();
        load(r2);
        exp_q.push_back(r2);
        pulse_start();
        wait_end("t2");
        chk("t2_status", status(), 32'b0100);
        chk("t2_known", 32'(board_known), 32'h1A0);
        chk("t2_assigned", 32'(board_assigned), 32'h180);
        chk("t2_pushes", push_cnt, 1);
        chk("t2_pending", exp_q.size(), 0);

        // 3: cell (1,0) preset filled via row 1, then column 0 keeps only 00010
        do_reset();
        load(mk(1, 1, 5'b00001, 5'b0, 5'b0, 5'b0));
        load(mk(5, 2, 5'b00100, 5'b00010, 5'b0, 5'b0));
        pulse_start();
        wait_end("t3");
        chk("t3_status", status(), 32'b0100);
        chk("t3_known", 32'(board_known), 32'h1087E1);
        chk("t3_assigned", 32'(board_assigned), 32'h20);
        chk("t3_pushes", push_cnt, 0);

        // 4: row 2 preset all empty, then two contradicting options
        do_reset();
        load(mk(2, 1, 5'b00000, 5'b0, 5'b0, 5'b0));
        load(mk(2, 2, 5'b10000, 5'b00001, 5'b0, 5'b0));
        pulse_start();
        wait_end("t4");
        chk("t4_status", status(), 32'b0010);
        chk("t4_known", 32'(board_known), 32'h7C00);
        repeat (5) @(negedge clk);
        chk("t4_hold_status", status(), 32'b0010);
        chk("t4_hold_known", 32'(board_known), 32'h7C00);
        chk("t4_pushes", push_cnt, 0);

        // 5: push held off by fifo_full, then exactly one pulse
        do_reset();
        fif.fifo_full = 1'b1;
        load(r2);
        exp_q.push_back(r2);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_wr_held", 32'(fif.fifo_wr_en), 32'h0);
        end
        chk("t5_busy_held", 32'(busy), 32'h1);
        chk("t5_data_held", 32'(fif.fifo_wr_data), 32'(r2));
        fif.fifo_full = 1'b0;
        wait_end("t5");
        chk("t5_pushes", push_cnt, 1);
        chk("t5_pending", exp_q.size(), 0);
        chk("t5_status", status(), 32'b0100);

        // 6: asynchronous reset in the middle of FILTER
        do_reset();
        load(mk(0, 1, 5'b10110, 5'b0, 5'b0, 5'b0));
        load(mk(1, 4, 5'b11100, 5'b01110, 5'b00111, 5'b11000));
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (board_known != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_first_commit", 32'(seen), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_known", 32'(board_known), 32'h0);
        chk("t6_assigned", 32'(board_assigned), 32'h0);
        chk("t6_status", status(), 32'h0);
        chk("t6_wr_data", 32'(fif.fifo_wr_data), 32'h0);
        chk("t6_strobes", {30'd0, fif.fifo_rd_en, fif.fifo_wr_en}, 32'h0);

`ifdef NONO_STALL_DETECT_EN
        // Stall: one progressing line followed by ten identical no-progress lines
        do_reset();
        for (int i = 0; i < 11; i++) begin
            load(r2);
            if (i < 10) exp_q.push_back(r2);
        end
        pulse_start();
        wait_end("stall");
        chk("stall_status", status(), 32'b0001);
        chk("stall_pushes", push_cnt, 10);
        chk("stall_known", 32'(board_known), 32'h1A0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
